impact_sram_sequencer: RTL

Parametrised digital access sequencer for the IMPACT 6T SRAM research banks. It replaces direct pad access to wordlines and bitlines with an on-chip state machine that generates precharge, wordline, write-drive and sense-enable pulses with programmable widths. It supports multiple banks and configurable array geometry. It sits between a host-side request interface (Wishbone adapter or logic analyzer) and the black-boxed analog bank macros plus their sense amplifiers.

---
 rtl/impact_sram_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/impact_sram_sequencer.sv
// Access sequencer for the IMPACT 6T SRAM banks: turns one host request into
// precharge / wordline / write-drive / sense pulses with programmable widths.
module impact_sram_sequencer #(
   parameter  int ROWS  = 32,
   parameter  int COLS  = 32,
   parameter  int BANKS = 4,
   parameter  int TW    = 4,
   localparam int RW    = $clog2(ROWS),
   localparam int BW    = (BANKS > 1) ? $clog2(BANKS) : 1
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_ni,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [BW-1:0]         req_bank,
   input  logic [RW-1:0]         req_row,
   input  logic [COLS-1:0]       req_wdata,
   input  logic [TW-1:0]         cfg_t_pre,
   input  logic [TW-1:0]         cfg_t_wl,
   input  logic [TW-1:0]         cfg_t_sense,
   output logic                  rsp_valid,
   output logic                  rsp_err,
   output logic [COLS-1:0]       rsp_rdata,
   output logic [BANKS*ROWS-1:0] wl_o,
   output logic                  pre_en_n,
   output logic                  bl_oe,
   output logic [COLS-1:0]       bl_out,
   output logic [COLS-1:0]       blb_out,
   output logic                  sa_en,
   input  logic [COLS-1:0]       sa_in,
   output logic                  busy
);

   localparam int NWL = BANKS * ROWS;

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_WL, S_SENSE, S_RECOVER} state_t;

   state_t          r_state;
   logic [TW-1:0]   r_cnt;
   logic [TW-1:0]   r_t_wl;
   logic [TW-1:0]   r_t_sense;
   logic            r_we;
   logic            r_err;
   logic [BW-1:0]   r_bank;
   logic [RW-1:0]   r_row;
   logic [COLS-1:0] r_wdata;

   logic            w_req_err;
   logic [NWL-1:0]  w_wl_onehot;

   assign w_req_err = (int'(req_bank) >= BANKS) || (int'(req_row) >= ROWS);

   // An out-of-range request decodes to no wordline at all.
   always_comb begin
      w_wl_onehot = '0;
      for (int i = 0; i < NWL; i++)
         w_wl_onehot[i] = !r_err && (i == (int'(r_bank) * ROWS + int'(r_row)));
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_t_wl    <= '0;
         r_t_sense <= '0;
         r_we      <= 1'b0;
         r_err     <= 1'b0;
         r_bank    <= '0;
         r_row     <= '0;
         r_wdata   <= '0;
         req_ready <= 1'b1;
         busy      <= 1'b0;
         pre_en_n  <= 1'b0;
         wl_o      <= '0;
         bl_oe     <= 1'b0;
         bl_out    <= '0;
         blb_out   <= '0;
         sa_en     <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (req_valid) begin
               r_state   <= S_PRE;
               r_cnt     <= cfg_t_pre;
               r_t_wl    <= cfg_t_wl;
               r_t_sense <= cfg_t_sense;
               r_we      <= req_we;
               r_err     <= w_req_err;
               r_bank    <= req_bank;
               r_row     <= req_row;
               r_wdata   <= req_wdata;
               req_ready <= 1'b0;
               busy      <= 1'b1;
            end
            S_PRE: if (r_cnt == '0) begin
               r_state  <= S_WL;
               r_cnt    <= r_t_wl;
               pre_en_n <= 1'b1;
               wl_o     <= w_wl_onehot;
               bl_oe    <= r_we;
               bl_out   <= r_we ? r_wdata : '0;
               blb_out  <= r_we ? ~r_wdata : '0;
            end else begin
               r_cnt <= r_cnt - 1'b1;
            end
            S_WL: if (r_cnt == '0) begin
               if (r_we) begin
                  r_state   <= S_RECOVER;
                  wl_o      <= '0;
                  pre_en_n  <= 1'b0;
                  bl_oe     <= 1'b0;
                  bl_out    <= '0;
                  blb_out   <= '0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= r_err;
               end else begin
                  r_state <= S_SENSE;
                  r_cnt   <= r_t_sense;
                  sa_en   <= 1'b1;
               end
            end else begin
               r_cnt <= r_cnt - 1'b1;
            end
            // Sense data is captured on the edge that closes the sense window.
            S_SENSE: if (r_cnt == '0) begin
               r_state   <= S_RECOVER;
               rsp_rdata <= r_err ? '0 : sa_in;
               wl_o      <= '0;
               sa_en     <= 1'b0;
               pre_en_n  <= 1'b0;
               rsp_valid <= 1'b1;
               rsp_err   <= r_err;
            end else begin
               r_cnt <= r_cnt - 1'b1;
            end
            S_RECOVER: begin
               r_state   <= S_IDLE;
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               req_ready <= 1'b1;
               busy      <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   a_no_pre_with_wl: assert property (@(posedge wb_clk_i) disable iff (!wb_rst_ni)
      !(!pre_en_n && (|wl_o)));
   a_no_oe_with_sa: assert property (@(posedge wb_clk_i) disable iff (!wb_rst_ni)
      !(bl_oe && sa_en));
   a_wl_onehot0: assert property (@(posedge wb_clk_i) disable iff (!wb_rst_ni)
      $onehot0(wl_o));

endmodule
